// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU: latches decoded operands and control,
// registers the ALU (ctrl, bin) pair and resolves EX/MEM and MEM/WB forwarding for the operands.
module id_ex_alu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_aluop,
    input  logic [5:0]  id_funct,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_ina,
    output logic [31:0] alu_inb,
    output logic [1:0]  alu_ctrl,
    output logic        alu_bin,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_illegal,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt
);

    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic        alusrc_q;

    logic [1:0]  dec_ctrl;
    logic        dec_bin;
    logic        dec_illegal;

    always_comb begin
        dec_ctrl    = 2'b00;
        dec_bin     = 1'b0;
        dec_illegal = 1'b0;
        case (id_aluop)
            2'b00: dec_ctrl = 2'b10;
            2'b01: begin
                dec_ctrl = 2'b10;
                dec_bin  = 1'b1;
            end
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_ctrl = 2'b10;
                    6'b100010: begin
                        dec_ctrl = 2'b10;
                        dec_bin  = 1'b1;
                    end
                    6'b100100: dec_ctrl = 2'b00;
                    6'b100101: dec_ctrl = 2'b01;
                    6'b101010: begin
                        dec_ctrl = 2'b11;
                        dec_bin  = 1'b1;
                    end
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // An invalid ID slot is loaded exactly like a flush bubble; stall only holds when not flushing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_illegal  <= 1'b0;
            alu_ctrl    <= 2'b00;
            alu_bin     <= 1'b0;
            alusrc_q    <= 1'b0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm_q       <= 32'd0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_dest     <= 5'd0;
        end else if (flush || (!stall && !id_valid)) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_illegal  <= 1'b0;
            alu_ctrl    <= 2'b00;
            alu_bin     <= 1'b0;
            alusrc_q    <= 1'b0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm_q       <= 32'd0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_dest     <= 5'd0;
        end else if (!stall) begin
            ex_valid    <= 1'b1;
            ex_regwrite <= id_regwrite && !dec_illegal;
            ex_memread  <= id_memread && !dec_illegal;
            ex_memwrite <= id_memwrite && !dec_illegal;
            ex_memtoreg <= id_memtoreg;
            ex_illegal  <= dec_illegal;
            alu_ctrl    <= dec_ctrl;
            alu_bin     <= dec_bin;
            alusrc_q    <= id_alusrc;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_dest     <= id_regdst ? id_rd : id_rt;
        end
    end

    // EX/MEM is only a legal source when this stage holds a real instruction; $0 never forwards.
    function automatic logic [31:0] forward(input logic [4:0] src, input logic [31:0] rf_data);
        if (ex_valid && exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src))
            return exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src))
            return memwb_result;
        else
            return rf_data;
    endfunction

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    assign fwd_rs        = forward(ex_rs, rs_data_q);
    assign fwd_rt        = forward(ex_rt, rt_data_q);
    assign alu_ina       = fwd_rs;
    assign alu_inb       = alusrc_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Self-checking bench for id_ex_alu_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [1:0]  id_aluop = '0;
    logic [5:0]  id_funct = '0;
    logic        id_alusrc = 0, id_regdst = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0, id_memtoreg = 0;
    logic        exmem_regwrite = 0, memwb_regwrite = 0;
    logic [4:0]  exmem_rd = '0, memwb_rd = '0;
    logic [31:0] exmem_result = '0, memwb_result = '0;
    logic [31:0] alu_ina, alu_inb, ex_store_data;
    logic [1:0]  alu_ctrl;
    logic        alu_bin;
    logic [4:0]  ex_dest, ex_rs, ex_rt;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;

    int tests = 0;
    int failures = 0;

    id_ex_alu_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_ctrl(alu_ctrl), .alu_bin(alu_bin),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal), .ex_rs(ex_rs), .ex_rt(ex_rt)
    );

    always #5 clk = ~clk;

    // Reference model: one latched instruction, described by its ALU operation.
    typedef enum { OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_BAD } op_t;

    typedef struct packed {
        logic        valid, regwrite, memread, memwrite, memtoreg, illegal, alusrc, bin;
        logic [1:0]  ctrl;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dest;
    } ent_t;

    ent_t cur = '0;

    function automatic op_t alu_op_of(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'd0) return OP_ADD;
        if (aluop == 2'd1) return OP_SUB;
        if (aluop == 2'd3) return OP_BAD;
        case (funct)
            6'd32:   return OP_ADD;
            6'd34:   return OP_SUB;
            6'd36:   return OP_AND;
            6'd37:   return OP_OR;
            6'd42:   return OP_SLT;
            default: return OP_BAD;
        endcase
    endfunction

    function automatic ent_t model_latch();
        ent_t e = '0;
        op_t  op;
        if (!id_valid) return e;
        op = alu_op_of(id_aluop, id_funct);
        e.valid    = 1'b1;
        e.illegal  = (op == OP_BAD);
        e.regwrite = id_regwrite && (op != OP_BAD);
        e.memread  = id_memread && (op != OP_BAD);
        e.memwrite = id_memwrite && (op != OP_BAD);
        e.memtoreg = id_memtoreg;
        e.ctrl     = (op == OP_AND) ? 2'd0 : (op == OP_OR) ? 2'd1 : (op == OP_SLT) ? 2'd3 :
                     (op == OP_BAD) ? 2'd0 : 2'd2;
        e.bin      = (op == OP_SUB) || (op == OP_SLT);
        e.alusrc   = id_alusrc;
        e.rs_data  = id_rs_data;
        e.rt_data  = id_rt_data;
        e.imm      = id_imm;
        e.rs       = id_rs;
        e.rt       = id_rt;
        e.dest     = id_regdst ? id_rd : id_rt;
        return e;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        if (cur.valid && exmem_regwrite && exmem_rd == r) return exmem_result;
        if (memwb_regwrite && memwb_rd == r) return memwb_result;
        return rf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string where);
        chk({where, ".alu_ina"}, alu_ina, model_fwd(cur.rs, cur.rs_data));
        chk({where, ".alu_inb"}, alu_inb, cur.alusrc ? cur.imm : model_fwd(cur.rt, cur.rt_data));
        chk({where, ".store"}, ex_store_data, model_fwd(cur.rt, cur.rt_data));
        chk({where, ".ctrl"}, 32'(alu_ctrl), 32'(cur.ctrl));
        chk({where, ".bin"}, 32'(alu_bin), 32'(cur.bin));
        chk({where, ".valid"}, 32'(ex_valid), 32'(cur.valid));
        chk({where, ".regwrite"}, 32'(ex_regwrite), 32'(cur.regwrite));
        chk({where, ".memread"}, 32'(ex_memread), 32'(cur.memread));
        chk({where, ".memwrite"}, 32'(ex_memwrite), 32'(cur.memwrite));
        chk({where, ".memtoreg"}, 32'(ex_memtoreg), 32'(cur.memtoreg));
        chk({where, ".illegal"}, 32'(ex_illegal), 32'(cur.illegal));
        chk({where, ".dest"}, 32'(ex_dest), 32'(cur.dest));
        chk({where, ".rs"}, 32'(ex_rs), 32'(cur.rs));
        chk({where, ".rt"}, 32'(ex_rt), 32'(cur.rt));
    endtask

    // Advance one clock edge, updating the model with the inputs present at the edge.
    task automatic step();
        ent_t n;
        if (rst)        n = '0;
        else if (flush) n = '0;
        else if (stall) n = cur;
        else            n = model_latch();
        @(posedge clk);
        cur = n;
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [1:0] aluop, input logic [5:0] funct,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                                  input logic [5:0] ctl);
        id_valid = v; id_aluop = aluop; id_funct = funct;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        exmem_regwrite = ew; exmem_rd = erd; exmem_result = eres;
        memwb_regwrite = ww; memwb_rd = wrd; memwb_result = wres;
    endtask

    task automatic randomize_id();
        logic [5:0] functs [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        apply_stimulus(($urandom_range(0, 7) != 0), 2'($urandom), functs[$urandom_range(0, 5)],
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       $urandom, $urandom, $urandom, 6'($urandom));
    endtask

    task automatic randomize_fwd();
        set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] sweep_funct [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        logic [1:0] sweep_ctrl  [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
        logic       sweep_bin   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        step();
        step();
        check_output("reset");
        chk("reset.valid_const", 32'(ex_valid), 32'd0);
        rst = 1'b0;

        // Decode sweep over legal R-type functs, then an illegal one
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 2'b10, sweep_funct[i], 5'd1, 5'd2, 5'd3, 32'h100 + i, 32'h200 + i, 32'd0, 6'b010100);
            step();
            check_output("sweep");
            chk("sweep.ctrl_const", 32'(alu_ctrl), 32'(sweep_ctrl[i]));
            chk("sweep.bin_const", 32'(alu_bin), 32'(sweep_bin[i]));
        end
        apply_stimulus(1'b1, 2'b10, 6'd0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'd0, 6'b011110);
        step();
        check_output("illegal");
        chk("illegal.flag", 32'(ex_illegal), 32'd1);
        chk("illegal.regwrite", 32'(ex_regwrite), 32'd0);

        // Forwarding priority on rs=5
        apply_stimulus(1'b1, 2'b00, 6'd0, 5'd5, 5'd6, 5'd0, 32'h33333333, 32'h44444444, 32'd0, 6'b000100);
        step();
        set_fwd(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222);
        #1;
        chk("fwd.exmem_wins", alu_ina, 32'h11111111);
        exmem_regwrite = 1'b0;
        #1;
        chk("fwd.memwb", alu_ina, 32'h22222222);
        check_output("fwd");

        // Register 0 is never forwarded
        apply_stimulus(1'b1, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 6'b000100);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        set_fwd(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF);
        #1;
        chk("reg0.alu_ina", alu_ina, 32'd0);

        // Store word: immediate operand, forwarded store data
        apply_stimulus(1'b1, 2'b00, 6'd0, 5'd4, 5'd7, 5'd0, 32'h1000, 32'h0, 32'h00000010, 6'b100010);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        set_fwd(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
        #1;
        chk("sw.alu_inb", alu_inb, 32'h00000010);
        chk("sw.store", ex_store_data, 32'hCAFEF00D);
        chk("sw.ctrl", 32'(alu_ctrl), 32'd2);
        chk("sw.bin", 32'(alu_bin), 32'd0);
        check_output("sw");

        // Stall three cycles with fresh ID inputs, then stall+flush
        apply_stimulus(1'b1, 2'b10, 6'd42, 5'd3, 5'd4, 5'd9, 32'h55, 32'h66, 32'h77, 6'b011000);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            step();
            check_output("stall");
            chk("stall.ctrl_held", 32'(alu_ctrl), 32'd3);
        end
        flush = 1'b1;
        step();
        check_output("flush");
        chk("flush.valid", 32'(ex_valid), 32'd0);
        chk("flush.regwrite", 32'(ex_regwrite), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // Asynchronous reset mid-cycle with a valid entry held
        apply_stimulus(1'b1, 2'b01, 6'd0, 5'd2, 5'd3, 5'd4, 32'h9, 32'h8, 32'h7, 6'b001110);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        chk("prereset.valid", 32'(ex_valid), 32'd1);
        #2;
        rst = 1'b1;
        cur = '0;
        #1;
        check_output("async_reset");
        chk("async_reset.regwrite", 32'(ex_regwrite), 32'd0);
        chk("async_reset.bin", 32'(alu_bin), 32'd0);
        #1;
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            randomize_id();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step();
            randomize_fwd();
            #1;
            check_output("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
